// File: rtl/mem_bus_arb.sv
// -----------------------------------------------------------------------------
// mem_bus_arb
//
// Purpose:
//   Shares one downstream memory bus between the instruction-fetch port (IF)
//   and the data-access port (MEM). MEM has fixed priority, but a starvation
//   guard hands the bus to IF after STARVE_LIMIT consecutive MEM completions
//   while IF was waiting. One transaction is in flight at a time. The grant is
//   held in a small FSM, and ready/read-data/response are routed back only to
//   the granted requester.
//
// Handshake (all three interfaces):
//   A requester raises x_valid_i with stable address/size/data and holds it
//   until x_ready_o. x_ready_o is a single-cycle pulse that is combinationally
//   equal to bus_valid_o && bus_ready_i while x is granted. Read data and
//   response are only meaningful in that pulse cycle. If a requester drops
//   valid before completion, the request is abandoned: bus_valid_o falls in
//   the same cycle and no ready pulse is produced. bus_ready_i is ignored
//   whenever bus_valid_o is low.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_valid_i/addr/size          IF request (always a read)
//   if_ready_o/data_read/resp     IF completion
//   dm_valid_i/req/addr/size/data MEM request (req: 1 write, 0 read)
//   dm_ready_o/data_read/resp     MEM completion
//   bus_*                         downstream memory bus
//   arb_grant_o                   00 none, 01 IF, 10 MEM (state decode)
//   arb_busy_o                    high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_bus_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_valid_i,
    input  logic [63:0] if_addr_i,
    input  logic [1:0]  if_size_i,
    output logic        if_ready_o,
    output logic [63:0] if_data_read_o,
    output logic [1:0]  if_resp_o,

    input  logic        dm_valid_i,
    input  logic        dm_req_i,
    input  logic [63:0] dm_addr_i,
    input  logic [1:0]  dm_size_i,
    input  logic [63:0] dm_data_write_i,
    output logic        dm_ready_o,
    output logic [63:0] dm_data_read_o,
    output logic [1:0]  dm_resp_o,

    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_req_o,
    output logic [63:0] bus_addr_o,
    output logic [1:0]  bus_size_o,
    output logic [63:0] bus_data_write_o,
    input  logic [63:0] bus_data_read_i,
    input  logic [1:0]  bus_resp_i,

    output logic [1:0]  arb_grant_o,
    output logic        arb_busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_below;
    logic             w_dm_done;
    logic             w_enter_if;

    assign w_cnt_below = (r_cnt < LP_LIMIT);

    // Next-state and all bus/requester outputs. Everything defaults to zero so
    // IDLE and the non-granted port read as quiet.
    always_comb begin
        w_state_nxt      = r_state;
        w_dm_done        = 1'b0;
        bus_valid_o      = 1'b0;
        bus_req_o        = 1'b0;
        bus_addr_o       = 64'h0;
        bus_size_o       = 2'b00;
        bus_data_write_o = 64'h0;
        if_ready_o       = 1'b0;
        if_data_read_o   = 64'h0;
        if_resp_o        = 2'b00;
        dm_ready_o       = 1'b0;
        dm_data_read_o   = 64'h0;
        dm_resp_o        = 2'b00;

        case (r_state)
            IDLE: begin
                // MEM wins unless IF is waiting and the guard has saturated.
                if (dm_valid_i && (!if_valid_i || w_cnt_below)) begin
                    w_state_nxt = GNT_DM;
                end else if (if_valid_i) begin
                    w_state_nxt = GNT_IF;
                end
            end

            GNT_IF: begin
                bus_valid_o = if_valid_i;
                bus_addr_o  = if_addr_i;
                bus_size_o  = if_size_i;
                if (!if_valid_i) begin
                    // Flushed before completion: abandon without a pulse.
                    w_state_nxt = IDLE;
                end else if (bus_ready_i) begin
                    if_ready_o     = 1'b1;
                    if_data_read_o = bus_data_read_i;
                    if_resp_o      = bus_resp_i;
                    w_state_nxt    = IDLE;
                end
            end

            GNT_DM: begin
                bus_valid_o      = dm_valid_i;
                bus_req_o        = dm_req_i;
                bus_addr_o       = dm_addr_i;
                bus_size_o       = dm_size_i;
                bus_data_write_o = dm_data_write_i;
                if (!dm_valid_i) begin
                    w_state_nxt = IDLE;
                end else if (bus_ready_i) begin
                    dm_ready_o     = 1'b1;
                    dm_data_read_o = bus_data_read_i;
                    dm_resp_o      = bus_resp_i;
                    w_dm_done      = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_enter_if = (r_state == IDLE) && (w_state_nxt == GNT_IF);

    // Starvation counter: counts MEM completions that happened while IF was
    // waiting. Any cycle without an IF request, or handing the bus to IF,
    // starts the count over.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!if_valid_i || w_enter_if) begin
            w_cnt_nxt = '0;
        end else if (w_dm_done && w_cnt_below) begin
            w_cnt_nxt = r_cnt + LP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign arb_grant_o = {(r_state == GNT_DM), (r_state == GNT_IF)};
    assign arb_busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arb
//
// Self-checking bench for mem_bus_arb. A downstream responder completes each
// bus transaction after `lat` cycles of bus_valid_o, returning address ^ key
// as read data. Expected completions are queued per port when a request is
// driven and popped when the matching ready pulse appears. Expected grant
// order is queued per scenario and popped whenever a new grant starts.
// -----------------------------------------------------------------------------
module tb_mem_bus_arb;

    localparam logic [63:0] RSP_KEY = 64'h0000_0013_8000_0093;

    logic        clk;
    logic        rst;
    logic        if_valid_i;
    logic [63:0] if_addr_i;
    logic [1:0]  if_size_i;
    logic        if_ready_o;
    logic [63:0] if_data_read_o;
    logic [1:0]  if_resp_o;
    logic        dm_valid_i;
    logic        dm_req_i;
    logic [63:0] dm_addr_i;
    logic [1:0]  dm_size_i;
    logic [63:0] dm_data_write_i;
    logic        dm_ready_o;
    logic [63:0] dm_data_read_o;
    logic [1:0]  dm_resp_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_req_o;
    logic [63:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic [63:0] bus_data_write_o;
    logic [63:0] bus_data_read_i;
    logic [1:0]  bus_resp_i;
    logic [1:0]  arb_grant_o;
    logic        arb_busy_o;

    mem_bus_arb #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid_i       (if_valid_i),
        .if_addr_i        (if_addr_i),
        .if_size_i        (if_size_i),
        .if_ready_o       (if_ready_o),
        .if_data_read_o   (if_data_read_o),
        .if_resp_o        (if_resp_o),
        .dm_valid_i       (dm_valid_i),
        .dm_req_i         (dm_req_i),
        .dm_addr_i        (dm_addr_i),
        .dm_size_i        (dm_size_i),
        .dm_data_write_i  (dm_data_write_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_read_o   (dm_data_read_o),
        .dm_resp_o        (dm_resp_o),
        .bus_valid_o      (bus_valid_o),
        .bus_ready_i      (bus_ready_i),
        .bus_req_o        (bus_req_o),
        .bus_addr_o       (bus_addr_o),
        .bus_size_o       (bus_size_o),
        .bus_data_write_o (bus_data_write_o),
        .bus_data_read_i  (bus_data_read_i),
        .bus_resp_i       (bus_resp_i),
        .arb_grant_o      (arb_grant_o),
        .arb_busy_o       (arb_busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int          n_checks;
    int          n_fail;
    logic [65:0] exp_if_q[$];      // {read data, resp}
    logic [65:0] exp_dm_q[$];
    logic [1:0]  exp_gnt_q[$];
    logic [1:0]  gnt_log[$];
    logic        bv_log[$];
    int          lat;
    int          wait_cnt;
    logic [1:0]  rsp_resp;
    logic [1:0]  prev_gnt;
    int          if_left;
    int          dm_left;
    int          if_pulses;
    int          dm_pulses;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({bus_valid_o, bus_req_o, bus_size_o, if_ready_o, dm_ready_o,
                                  if_resp_o, dm_resp_o, arb_grant_o, arb_busy_o}), 64'h0);
        check({tag, "_addr"},  bus_addr_o,       64'h0);
        check({tag, "_wdata"}, bus_data_write_o, 64'h0);
        check({tag, "_if_rd"}, if_data_read_o,   64'h0);
        check({tag, "_dm_rd"}, dm_data_read_o,   64'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic start_if(input logic [63:0] addr);
        if_valid_i = 1'b1;
        if_addr_i  = addr;
        if_size_i  = 2'($urandom_range(0, 3));
        exp_if_q.push_back({addr ^ RSP_KEY, rsp_resp});
    endtask

    task automatic start_dm(input logic req, input logic [63:0] addr, input logic [63:0] wdata);
        dm_valid_i      = 1'b1;
        dm_req_i        = req;
        dm_addr_i       = addr;
        dm_size_i       = 2'($urandom_range(0, 3));
        dm_data_write_i = wdata;
        exp_dm_q.push_back({addr ^ RSP_KEY, rsp_resp});
    endtask

    function automatic logic [63:0] rand_addr();
        return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)};
    endfunction

    // One clock cycle: entered and left at posedge + 1.
    task automatic step();
        logic [65:0] e;
        logic [1:0]  eg;
        logic        if_done;
        logic        dm_done;
        #1;
        bus_ready_i     = bus_valid_o && (wait_cnt == lat - 1);
        bus_data_read_i = bus_addr_o ^ RSP_KEY;
        bus_resp_i      = rsp_resp;
        #1;
        gnt_log.push_back(arb_grant_o);
        bv_log.push_back(bus_valid_o);

        if (arb_grant_o != 2'b00 && prev_gnt == 2'b00) begin
            if (exp_gnt_q.size() == 0) begin
                check("gnt_unexpected", 64'(arb_grant_o), 64'h0);
            end else begin
                eg = exp_gnt_q.pop_front();
                check("gnt_order", 64'(arb_grant_o), 64'(eg));
            end
        end

        if (bus_valid_o && arb_grant_o == 2'b01) begin
            check("if_bus_addr", bus_addr_o, if_addr_i);
            check("if_bus_ctl", 64'({bus_req_o, bus_size_o}), 64'({1'b0, if_size_i}));
        end
        if (bus_valid_o && arb_grant_o == 2'b10) begin
            check("dm_bus_addr", bus_addr_o, dm_addr_i);
            check("dm_bus_ctl", 64'({bus_req_o, bus_size_o}), 64'({dm_req_i, dm_size_i}));
            check("dm_bus_wdata", bus_data_write_o, dm_data_write_i);
        end

        if (if_ready_o) begin
            if_pulses++;
            if (exp_if_q.size() == 0) begin
                check("if_ready_unexpected", 64'(if_ready_o), 64'h0);
            end else begin
                e = exp_if_q.pop_front();
                check("if_rdata", if_data_read_o, e[65:2]);
                check("if_resp", 64'(if_resp_o), 64'(e[1:0]));
            end
            check("dm_quiet_on_if", 64'({dm_ready_o, dm_resp_o}), 64'h0);
            check("dm_rd_quiet_on_if", dm_data_read_o, 64'h0);
        end
        if (dm_ready_o) begin
            dm_pulses++;
            if (exp_dm_q.size() == 0) begin
                check("dm_ready_unexpected", 64'(dm_ready_o), 64'h0);
            end else begin
                e = exp_dm_q.pop_front();
                check("dm_rdata", dm_data_read_o, e[65:2]);
                check("dm_resp", 64'(dm_resp_o), 64'(e[1:0]));
            end
            check("if_quiet_on_dm", 64'({if_ready_o, if_resp_o}), 64'h0);
            check("if_rd_quiet_on_dm", if_data_read_o, 64'h0);
        end

        if (bus_valid_o && !bus_ready_i) wait_cnt++;
        else wait_cnt = 0;
        prev_gnt = arb_grant_o;
        if_done  = if_ready_o;
        dm_done  = dm_ready_o;

        @(posedge clk);
        #1;
        bus_ready_i = 1'b0;
        if (if_done) begin
            if_valid_i = 1'b0;
            if (if_left > 0) begin
                if_left--;
                start_if(rand_addr());
            end
        end
        if (dm_done) begin
            dm_valid_i = 1'b0;
            if (dm_left > 0) begin
                dm_left--;
                start_dm(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
            end
        end
    endtask

    // Step until all queued work has completed, bounded by max cycles.
    task automatic run(input int max);
        int n;
        n = 0;
        while ((exp_if_q.size() + exp_dm_q.size() != 0 || if_valid_i || dm_valid_i) && n < max) begin
            step();
            n++;
        end
        check("drain_pending", 64'(exp_if_q.size() + exp_dm_q.size()), 64'h0);
    endtask

    task automatic new_test();
        gnt_log.delete();
        bv_log.delete();
        if_pulses = 0;
        dm_pulses = 0;
        if_left   = 0;
        dm_left   = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] exp_seq[5];
        logic       exp_bv[5];

        n_checks = 0;
        n_fail   = 0;
        rst             = 1'b0;
        if_valid_i      = 1'b0;
        if_addr_i       = 64'h0;
        if_size_i       = 2'b00;
        dm_valid_i      = 1'b0;
        dm_req_i        = 1'b0;
        dm_addr_i       = 64'h0;
        dm_size_i       = 2'b00;
        dm_data_write_i = 64'h0;
        bus_ready_i     = 1'b0;
        bus_data_read_i = 64'h0;
        bus_resp_i      = 2'b00;
        lat       = 1;
        wait_cnt  = 0;
        rsp_resp  = 2'b00;
        prev_gnt  = 2'b00;
        new_test();

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // IF-only read, 3-cycle downstream latency
        new_test();
        lat = 3;
        exp_gnt_q.push_back(2'b01);
        start_if(64'h0000_0000_8000_0000);
        run(40);
        step();
        exp_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_bv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            check("ifonly_gnt_seq", 64'(gnt_log[i]), 64'(exp_seq[i]));
            check("ifonly_bv_seq", 64'(bv_log[i]), 64'(exp_bv[i]));
        end
        check("ifonly_if_pulses", 64'(if_pulses), 64'd1);
        check("ifonly_dm_pulses", 64'(dm_pulses), 64'd0);

        // Simultaneous request, counter 0: MEM first, one IDLE, then IF
        new_test();
        lat = 1;
        exp_gnt_q.push_back(2'b10);
        exp_gnt_q.push_back(2'b01);
        start_dm(1'b1, 64'h0000_0000_8000_1000, 64'h0000_0000_DEAD_BEEF);
        start_if(64'h0000_0000_8000_2000);
        run(40);
        step();
        exp_seq = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            check("simul_gnt_seq", 64'(gnt_log[i]), 64'(exp_seq[i]));
        end

        // Starvation: IF held while MEM issues 6 back-to-back requests
        new_test();
        lat = 1;
        dm_left = 5;
        for (int i = 0; i < 4; i++) exp_gnt_q.push_back(2'b10);
        exp_gnt_q.push_back(2'b01);
        exp_gnt_q.push_back(2'b10);
        exp_gnt_q.push_back(2'b10);
        start_dm(1'b0, rand_addr(), 64'h0);
        start_if(rand_addr());
        run(100);
        check("starve_gnt_left", 64'(exp_gnt_q.size()), 64'h0);
        check("starve_if_pulses", 64'(if_pulses), 64'd1);
        check("starve_dm_pulses", 64'(dm_pulses), 64'd6);

        // Flush abort during GNT_IF
        new_test();
        lat = 8;
        if_valid_i = 1'b1;
        if_addr_i  = 64'h0000_0000_8000_3000;
        if_size_i  = 2'b10;
        step();
        #1;
        check("abort_bv_before", 64'(bus_valid_o), 64'd1);
        if_valid_i  = 1'b0;
        bus_ready_i = 1'b1;
        #1;
        check("abort_bv_same_cycle", 64'(bus_valid_o), 64'd0);
        check("abort_no_ready", 64'({if_ready_o, dm_ready_o}), 64'h0);
        check("abort_still_gnt", 64'(arb_grant_o), 64'h1);
        @(posedge clk);
        #1;
        bus_ready_i = 1'b0;
        check("abort_idle_next", 64'({arb_grant_o, arb_busy_o}), 64'h0);
        wait_cnt = 0;
        prev_gnt = 2'b00;
        lat = 2;
        exp_gnt_q.push_back(2'b10);
        start_dm(1'b0, rand_addr(), 64'h0);
        run(40);
        check("abort_after_dm_pulses", 64'(dm_pulses), 64'd1);
        check("abort_after_if_pulses", 64'(if_pulses), 64'd0);

        // Asynchronous reset mid-transaction in GNT_DM
        new_test();
        lat = 8;
        start_dm(1'b1, 64'h0000_0000_8000_4000, 64'h0123_4567_89AB_CDEF);
        step();
        #1;
        check("rstmid_bv_before", 64'(bus_valid_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        dm_valid_i = 1'b0;
        exp_dm_q.delete();
        wait_cnt = 0;
        prev_gnt = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_idle", 64'({arb_grant_o, arb_busy_o}), 64'h0);
        new_test();
        lat = 1;
        exp_gnt_q.push_back(2'b01);
        start_if(rand_addr());
        run(40);
        check("rstmid_if_latency_0", 64'(bv_log[0]), 64'd0);
        check("rstmid_if_latency_1", 64'(bv_log[1]), 64'd1);
        check("rstmid_if_pulses", 64'(if_pulses), 64'd1);

        // Error response on a MEM read
        new_test();
        lat = 2;
        rsp_resp = 2'b10;
        exp_gnt_q.push_back(2'b10);
        start_dm(1'b0, 64'h0000_0000_8000_5000, 64'h0);
        run(40);
        check("err_dm_pulses", 64'(dm_pulses), 64'd1);
        check("err_if_pulses", 64'(if_pulses), 64'd0);
        rsp_resp = 2'b00;

        check("final_gnt_left", 64'(exp_gnt_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
